// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop synchronizer, per-bit debounce and press pulse for six buttons.
// Define BTN_AUTOREPEAT_EN to build auto-repeat on the up/down keys (bits 1 and 2).
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Bderecha,
  input  logic       Barriba,
  input  logic       Babajo,
  input  logic       Bizquierda,
  input  logic       Bcentro,
  input  logic       Alarma_stop,
  output logic [5:0] level,
  output logic [5:0] pulse
);

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215) begin : g_chk_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 2 || REPEAT_DELAY > 134217727) begin : g_chk_rd
    $error("REPEAT_DELAY out of range");
  end
  if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > 134217727) begin : g_chk_rp
    $error("REPEAT_PERIOD out of range");
  end

  logic [5:0]  raw;
  logic [5:0]  sync1;
  logic [5:0]  sync2;
  logic [5:0]  lvl_nxt;
  logic [5:0]  rise;
  logic [5:0]  rep_fire;
  logic [23:0] cnt     [6];
  logic [23:0] cnt_nxt [6];

  assign raw = {Alarma_stop, Bcentro, Bizquierda, Babajo, Barriba, Bderecha};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any agreement between sync2 and level discards the partial count.
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      lvl_nxt[i] = level[i];
      cnt_nxt[i] = '0;
      if (sync2[i] != level[i]) begin
        if (cnt[i] == DB_LAST) lvl_nxt[i] = sync2[i];
        else                   cnt_nxt[i] = cnt[i] + 24'd1;
      end
    end
  end

  assign rise = lvl_nxt & ~level;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      level <= lvl_nxt;
      pulse <= rise | rep_fire;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_t;

  localparam logic [26:0] RD_LAST = 27'(REPEAT_DELAY - 1);
  localparam logic [26:0] RP_LAST = 27'(REPEAT_PERIOD - 1);

  // Index j drives level/pulse bit j+1 (up, down).
  rep_state_t  st       [2];
  rep_state_t  st_nxt   [2];
  logic [26:0] rcnt     [2];
  logic [26:0] rcnt_nxt [2];
  logic [1:0]  fire;
  logic        conflict;

  assign conflict = lvl_nxt[1] & lvl_nxt[2];

  // Decisions use the next level so a falling or conflicting edge never fires a repeat.
  always_comb begin
    for (int unsigned j = 0; j < 2; j++) begin
      st_nxt[j]   = st[j];
      rcnt_nxt[j] = rcnt[j];
      fire[j]     = 1'b0;
      if (!lvl_nxt[j+1] || conflict) begin
        st_nxt[j]   = R_IDLE;
        rcnt_nxt[j] = '0;
      end else begin
        case (st[j])
          R_IDLE: begin
            rcnt_nxt[j] = '0;
            if (rise[j+1]) st_nxt[j] = R_DELAY;
          end
          R_DELAY: begin
            if (rcnt[j] == RD_LAST) begin
              fire[j]     = 1'b1;
              st_nxt[j]   = R_REPEAT;
              rcnt_nxt[j] = '0;
            end else begin
              rcnt_nxt[j] = rcnt[j] + 27'd1;
            end
          end
          R_REPEAT: begin
            if (rcnt[j] == RP_LAST) begin
              fire[j]     = 1'b1;
              rcnt_nxt[j] = '0;
            end else begin
              rcnt_nxt[j] = rcnt[j] + 27'd1;
            end
          end
          default: begin
            st_nxt[j]   = R_IDLE;
            rcnt_nxt[j] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned j = 0; j < 2; j++) begin
        st[j]   <= R_IDLE;
        rcnt[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        st[j]   <= st_nxt[j];
        rcnt[j] <= rcnt_nxt[j];
      end
    end
  end

  assign rep_fire = {3'b000, fire, 1'b0};
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE=8, DELAY=20, PERIOD=5).
module tb_btn_conditioner;

  logic       CLK;
  logic       RST;
  logic       Bderecha, Barriba, Babajo, Bizquierda, Bcentro, Alarma_stop;
  logic [5:0] level;
  logic [5:0] pulse;

  int tests;
  int fails;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Bderecha   (Bderecha),
    .Barriba    (Barriba),
    .Babajo     (Babajo),
    .Bizquierda (Bizquierda),
    .Bcentro    (Bcentro),
    .Alarma_stop(Alarma_stop),
    .level      (level),
    .pulse      (pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (level !== 6'b0 || pulse !== 6'b0) begin
        fails++;
        $display("FAIL reset_hold c=%0d level=%b pulse=%b exp=000000", c, level, pulse);
      end
    end
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (level !== 6'b0 || pulse !== 6'b0) begin
        fails++;
        $display("FAIL reset_idle c=%0d level=%b pulse=%b exp=000000", c, level, pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] el, ep;
    Bcentro = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      el = (c >= 9) ? 6'b010000 : 6'b0;
      ep = (c == 9) ? 6'b010000 : 6'b0;
      tests++;
      if (level !== el) begin
        fails++;
        $display("FAIL clean_level c=%0d got=%b exp=%b", c, level, el);
      end
      tests++;
      if (pulse !== ep) begin
        fails++;
        $display("FAIL clean_pulse c=%0d got=%b exp=%b", c, pulse, ep);
      end
    end
    Bcentro = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      el = (c < 9) ? 6'b010000 : 6'b0;
      tests++;
      if (level !== el || pulse !== 6'b0) begin
        fails++;
        $display("FAIL release_level c=%0d level=%b pulse=%b exp_level=%b exp_pulse=000000",
                 c, level, pulse, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] el, ep;
    for (int c = 0; c < 30; c++) begin
      Bderecha = ((c / 3) % 2 == 0);
      tick();
      tests++;
      if (level !== 6'b0 || pulse !== 6'b0) begin
        fails++;
        $display("FAIL bounce_quiet c=%0d level=%b pulse=%b exp=000000", c, level, pulse);
      end
    end
    Bderecha = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      el = (c >= 9) ? 6'b000001 : 6'b0;
      ep = (c == 9) ? 6'b000001 : 6'b0;
      tests++;
      if (level !== el || pulse !== ep) begin
        fails++;
        $display("FAIL bounce_settle c=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 c, level, pulse, el, ep);
      end
    end
    Bderecha = 1'b0;
    idle(12);
    tests++;
    if (level !== 6'b0) begin
      fails++;
      $display("FAIL bounce_release got=%b exp=000000", level);
    end
  endtask

  // Raw held through edge 68, so level falls at edge 78; p = edge 9.
  task automatic test_autorepeat();
    logic [5:0] el, ep;
    int d;
    for (int c = 0; c < 85; c++) begin
      Barriba = (c <= 68);
      tick();
      d  = c - 9;
      el = (c >= 9 && c < 78) ? 6'b000010 : 6'b0;
      ep = (c == 9) ? 6'b000010 : 6'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (d >= 20 && (d - 20) % 5 == 0 && c < 78) ep = 6'b000010;
`endif
      tests++;
      if (level !== el || pulse !== ep) begin
        fails++;
        $display("FAIL autorepeat c=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 c, level, pulse, el, ep);
      end
    end
    Barriba = 1'b0;
    idle(3);
  endtask

  task automatic test_updown();
    logic [5:0] el, ep;
    Barriba = 1'b1;
    Babajo  = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick();
      el = (c >= 9) ? 6'b000110 : 6'b0;
      ep = (c == 9) ? 6'b000110 : 6'b0;
      tests++;
      if (level !== el || pulse !== ep) begin
        fails++;
        $display("FAIL updown c=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 c, level, pulse, el, ep);
      end
    end
    Barriba = 1'b0;
    Babajo  = 1'b0;
    idle(12);
    tests++;
    if (level !== 6'b0 || pulse !== 6'b0) begin
      fails++;
      $display("FAIL updown_release level=%b pulse=%b exp=000000", level, pulse);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] el, ep;
    Bcentro = 1'b1;
    idle(12);
    Bizquierda = 1'b1;
    idle(7);  // Bizquierda counter now at 5
    tests++;
    if (level !== 6'b010000) begin
      fails++;
      $display("FAIL reset_mid_pre got=%b exp=010000", level);
    end
    RST = 1'b1;
    #1;
    tests++;
    if (level !== 6'b0 || pulse !== 6'b0) begin
      fails++;
      $display("FAIL reset_mid_async level=%b pulse=%b exp=000000", level, pulse);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (level !== 6'b0 || pulse !== 6'b0) begin
        fails++;
        $display("FAIL reset_mid_hold c=%0d level=%b pulse=%b exp=000000", c, level, pulse);
      end
    end
    RST = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      el = (c >= 9) ? 6'b011000 : 6'b0;
      ep = (c == 9) ? 6'b011000 : 6'b0;
      tests++;
      if (level !== el || pulse !== ep) begin
        fails++;
        $display("FAIL reset_mid_after c=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 c, level, pulse, el, ep);
      end
    end
    Bcentro    = 1'b0;
    Bizquierda = 1'b0;
    idle(12);
  endtask

  task automatic test_simultaneous();
    logic [5:0] el, ep;
    {Alarma_stop, Bcentro, Bizquierda, Babajo, Barriba, Bderecha} = 6'b111111;
    for (int c = 0; c < 25; c++) begin
      tick();
      el = (c >= 9) ? 6'b111111 : 6'b0;
      ep = (c == 9) ? 6'b111111 : 6'b0;
      tests++;
      if (level !== el || pulse !== ep) begin
        fails++;
        $display("FAIL simultaneous c=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 c, level, pulse, el, ep);
      end
    end
    {Alarma_stop, Bcentro, Bizquierda, Babajo, Barriba, Bderecha} = 6'b000000;
    idle(12);
    tests++;
    if (level !== 6'b0 || pulse !== 6'b0) begin
      fails++;
      $display("FAIL simultaneous_release level=%b pulse=%b exp=000000", level, pulse);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b1;
    {Alarma_stop, Bcentro, Bizquierda, Babajo, Barriba, Bderecha} = 6'b000000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_updown();
    test_reset_mid();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
